// File: rtl/spi_ram_ctrl_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_ctrl_v2_if
// Description : Command / read-data bundle between the SPI slave front end
//               and the RAM controller.
//                 rx_valid, rx_data : framed command word {opcode[2:0], payload}
//                 tx_ready          : downstream accepts tx_data this cycle
//                 tx_valid, tx_data : read word offered downstream
//                 busy              : controller is not idle
//                 err               : one-cycle pulse on a rejected command
//               master = command source / data sink, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_ram_ctrl_v2_if #(
    parameter int DATA_W = 8
) ();
    logic              rx_valid;
    logic [DATA_W+2:0] rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              err;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, busy, err
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/spi_ram_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_ctrl_v2
// Description : Command-decoding RAM controller. Decodes framed command words
//               into pointer updates, writes, single/burst reads with a
//               ready/valid output, and a sequential memory clear.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - spi_ram_ctrl_v2_if.slave (rx_valid, rx_data, tx_ready,
//                       tx_valid, tx_data, busy, err)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_ctrl_v2 #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AUTO_INC = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    spi_ram_ctrl_v2_if.slave   bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_tx   = 2'd1;
    localparam logic [1:0] c_st_clr  = 2'd2;

    localparam logic [2:0] c_op_set_waddr = 3'b000;
    localparam logic [2:0] c_op_write     = 3'b001;
    localparam logic [2:0] c_op_set_raddr = 3'b010;
    localparam logic [2:0] c_op_read      = 3'b011;
    localparam logic [2:0] c_op_burst     = 3'b100;
    localparam logic [2:0] c_op_clear     = 3'b101;

    localparam int              c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [2:0]        w_op;
    logic [DATA_W-1:0] w_payload;
    logic [ADDR_W-1:0] w_addr;
    logic              w_addr_ok;
    logic              w_idle;
    logic              w_accept;
    logic              w_reject;
    logic              w_cmd_ok;
    logic [ADDR_W-1:0] w_waddr_inc;
    logic [ADDR_W-1:0] w_raddr_inc;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_wr_en;
    logic [c_iw-1:0]   w_wr_idx;
    logic [DATA_W-1:0] w_wr_data;

    assign w_op      = bus.rx_data[DATA_W+2:DATA_W];
    assign w_payload = bus.rx_data[DATA_W-1:0];
    assign w_addr    = w_payload[ADDR_W-1:0];

    // An address is only legal if it lies inside the RAM and no payload bit
    // above the pointer width is set (the shift yields zero when ADDR_W==DATA_W).
    assign w_addr_ok = ({1'b0, w_addr} < c_depth) && ((w_payload >> ADDR_W) == '0);

    assign w_idle   = (r_state == c_st_idle);
    assign w_accept = bus.rx_valid && w_idle;

    always_comb begin
        w_reject = 1'b0;
        case (w_op)
            c_op_set_waddr,
            c_op_set_raddr: w_reject = !w_addr_ok;
            c_op_write,
            c_op_read,
            c_op_clear:     w_reject = 1'b0;
            c_op_burst:     w_reject = (w_payload == '0);
            default:        w_reject = 1'b1;
        endcase
    end

    assign w_cmd_ok = w_accept && !w_reject;

    assign w_waddr_inc = (r_waddr == c_last) ? '0 : r_waddr + 1'b1;
    assign w_raddr_inc = (r_raddr == c_last) ? '0 : r_raddr + 1'b1;
    assign w_rd_word   = r_mem[r_raddr[c_iw-1:0]];

    // Single write port shared by WRITE commands and the clear sweep; the two
    // never coincide because commands are only accepted while idle.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = r_waddr[c_iw-1:0];
        w_wr_data = w_payload;
        if (r_state == c_st_clr) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_clr_cnt[c_iw-1:0];
            w_wr_data = '0;
        end else if (w_cmd_ok && (w_op == c_op_write)) begin
            w_wr_en   = 1'b1;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_clr_cnt   <= '0;
            r_remaining <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Commands arriving while busy are dropped and flagged, as are
            // illegal commands arriving while idle.
            r_err <= bus.rx_valid && (!w_idle || w_reject);

            case (r_state)
                c_st_idle: begin
                    if (w_cmd_ok) begin
                        case (w_op)
                            c_op_set_waddr: r_waddr <= w_addr;
                            c_op_write: begin
                                if (AUTO_INC != 0) r_waddr <= w_waddr_inc;
                            end
                            c_op_set_raddr: r_raddr <= w_addr;
                            c_op_read: begin
                                r_tx_data   <= w_rd_word;
                                r_tx_valid  <= 1'b1;
                                r_remaining <= '0;
                                r_state     <= c_st_tx;
                                if (AUTO_INC != 0) r_raddr <= w_raddr_inc;
                            end
                            c_op_burst: begin
                                r_tx_data   <= w_rd_word;
                                r_tx_valid  <= 1'b1;
                                r_remaining <= w_payload - 1'b1;
                                r_state     <= c_st_tx;
                                r_raddr     <= w_raddr_inc;
                            end
                            c_op_clear: begin
                                r_clr_cnt <= '0;
                                r_state   <= c_st_clr;
                            end
                            default: ;
                        endcase
                    end
                end

                c_st_tx: begin
                    // Next word is fetched on the same edge the current one
                    // is taken, so bursts stream without bubbles.
                    if (bus.tx_ready) begin
                        if (r_remaining != '0) begin
                            r_tx_data   <= w_rd_word;
                            r_raddr     <= w_raddr_inc;
                            r_remaining <= r_remaining - 1'b1;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= c_st_idle;
                        end
                    end
                end

                c_st_clr: begin
                    if (r_clr_cnt == c_last) begin
                        r_waddr <= '0;
                        r_raddr <= '0;
                        r_state <= c_st_idle;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = (r_state != c_st_idle);
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_ctrl_v2
// Description : Self-checking bench for spi_ram_ctrl_v2 (DATA_W=8, ADDR_W=5,
//               DEPTH=16, AUTO_INC=1). A command-level reference model
//               predicts every output each cycle; directed sequences add
//               literal expectations, then random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl_v2;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_ram_ctrl_v2_if #(.DATA_W(8)) bus ();

    spi_ram_ctrl_v2 #(
        .DATA_W   (8),
        .ADDR_W   (5),
        .DEPTH    (DEPTH),
        .AUTO_INC (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (command level) ----------------
    int m_mem [DEPTH];
    int m_waddr = 0, m_raddr = 0;
    int m_words_left = 0;     // words still to send after the one on offer
    bit m_sending = 1'b0;     // a word is on offer
    int m_clr_left = 0;       // words the clear sweep still has to zero
    int m_tx = 0;
    bit m_err = 1'b0;

    task automatic model_step();
        bit was_busy;
        int op, pl;
        if (!rst_n) begin
            m_waddr = 0; m_raddr = 0; m_words_left = 0; m_sending = 0;
            m_clr_left = 0; m_tx = 0; m_err = 0;
            return;
        end
        was_busy = m_sending || (m_clr_left > 0);
        m_err = 0;
        if (m_sending) begin
            if (bus.tx_ready) begin
                if (m_words_left > 0) begin
                    m_tx = m_mem[m_raddr];
                    m_raddr = (m_raddr + 1) % DEPTH;
                    m_words_left--;
                end else begin
                    m_sending = 0;
                end
            end
        end else if (m_clr_left > 0) begin
            m_mem[DEPTH - m_clr_left] = 0;
            m_clr_left--;
            if (m_clr_left == 0) begin
                m_waddr = 0;
                m_raddr = 0;
            end
        end
        if (bus.rx_valid) begin
            op = int'(bus.rx_data[10:8]);
            pl = int'(bus.rx_data[7:0]);
            if (was_busy) m_err = 1;
            else case (op)
                0: if (pl >= DEPTH) m_err = 1; else m_waddr = pl;
                1: begin m_mem[m_waddr] = pl; m_waddr = (m_waddr + 1) % DEPTH; end
                2: if (pl >= DEPTH) m_err = 1; else m_raddr = pl;
                3: begin
                    m_tx = m_mem[m_raddr]; m_raddr = (m_raddr + 1) % DEPTH;
                    m_sending = 1; m_words_left = 0;
                end
                4: if (pl == 0) m_err = 1;
                   else begin
                       m_tx = m_mem[m_raddr]; m_raddr = (m_raddr + 1) % DEPTH;
                       m_sending = 1; m_words_left = pl - 1;
                   end
                5: m_clr_left = DEPTH;
                default: m_err = 1;
            endcase
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("tx_valid", int'(bus.tx_valid), int'(m_sending));
        chk("busy", int'(bus.busy), int'(m_sending || (m_clr_left > 0)));
        chk("err", int'(bus.err), int'(m_err));
        chk("tx_data", int'(bus.tx_data), m_tx);
    end

    // Words actually handed downstream.
    int got_q[$];
    always @(posedge clk) begin
        if (rst_n && bus.tx_valid && bus.tx_ready) got_q.push_back(int'(bus.tx_data));
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic cmd(input int op, input int pl);
        bus.rx_valid = 1'b1;
        bus.rx_data  = {3'(op), 8'(pl)};
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
    endtask

    task automatic idle_wait();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_one(input int addr, output int val);
        bus.tx_ready = 1'b1;
        got_q.delete();
        cmd(2, addr);
        cmd(3, 0);
        idle_wait();
        val = (got_q.size() > 0) ? got_q[0] : -1;
    endtask

    initial begin
        int n, v;
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", int'(bus.tx_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);

        // Known RAM contents before any read.
        cmd(5, 0);
        idle_wait();

        // Single write then read, busy for one cycle.
        bus.tx_ready = 1'b1;
        got_q.delete();
        cmd(0, 8'h0A); cmd(1, 8'hA5); cmd(2, 8'h0A); cmd(3, 0);
        busy_len(n);
        chk("read_busy_len", n, 1);
        chk("read_count", got_q.size(), 1);
        chk("read_data", got_q[0], 8'hA5);

        // Auto-increment wrap and burst across the top of the RAM.
        cmd(0, 14); cmd(1, 8'h11); cmd(1, 8'h22); cmd(1, 8'h33); cmd(1, 8'h44);
        cmd(2, 14);
        got_q.delete();
        cmd(4, 3);
        busy_len(n);
        chk("burst3_busy_len", n, 3);
        chk("burst3_count", got_q.size(), 3);
        chk("burst3_w0", got_q[0], 8'h11);
        chk("burst3_w1", got_q[1], 8'h22);
        chk("burst3_w2", got_q[2], 8'h33);
        got_q.delete();
        cmd(3, 0);
        idle_wait();
        chk("raddr_after_wrap", got_q[0], 8'h44);

        // Burst with back-pressure.
        cmd(0, 4); cmd(1, 8'h41); cmd(1, 8'h42); cmd(1, 8'h43); cmd(1, 8'h44);
        cmd(2, 4);
        got_q.delete();
        bus.tx_ready = 1'b0;
        cmd(4, 4);
        foreach (pat[i]) begin
            bus.tx_ready = pat[i][0];
            @(negedge clk);
        end
        chk("bp_tx_valid_end", int'(bus.tx_valid), 0);
        chk("bp_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_word", got_q[i], 8'h41 + i);

        // Command while busy is dropped.
        bus.tx_ready = 1'b0;
        cmd(2, 4); cmd(3, 0);
        cmd(1, 8'hEE);
        chk("busy_write_err", int'(bus.err), 1);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("busy_err_one_cycle", int'(bus.err), 0);
        idle_wait();
        read_one(8, v);
        chk("busy_write_dropped", v, 0);

        // Illegal commands.
        cmd(0, 8'h14); chk("oob_waddr_err", int'(bus.err), 1);
        cmd(7, 0);     chk("rsv_op_err", int'(bus.err), 1);
        cmd(4, 0);     chk("burst0_err", int'(bus.err), 1);
        cmd(2, 8'h30); chk("hibits_raddr_err", int'(bus.err), 1);
        cmd(6, 0);     chk("rsv6_err", int'(bus.err), 1);
        cmd(1, 8'h77);
        chk("write_no_err", int'(bus.err), 0);
        read_one(8, v);
        chk("waddr_unchanged", v, 8'h77);

        // Clear sweep.
        cmd(0, 0);
        for (int i = 0; i < DEPTH; i++) cmd(1, 8'h80 + i);
        cmd(5, 0);
        busy_len(n);
        chk("clear_busy_len", n, DEPTH);
        cmd(2, 0);
        got_q.delete();
        cmd(4, DEPTH);
        idle_wait();
        chk("clear_count", got_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("clear_word", got_q[i], 0);

        // Reset in the middle of a clear.
        cmd(0, 0);
        for (int i = 0; i < DEPTH; i++) cmd(1, 8'h80 + i);
        cmd(5, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midclr_rst_busy", int'(bus.busy), 0);
        chk("midclr_rst_tx_valid", int'(bus.tx_valid), 0);
        chk("midclr_rst_err", int'(bus.err), 0);
        chk("midclr_rst_tx_data", int'(bus.tx_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_one(15, v);
        chk("midclr_kept", v, 8'h8F);
        read_one(0, v);
        chk("midclr_cleared", v, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            bus.tx_ready = ($urandom_range(0, 2) != 0);
            bus.rx_valid = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 99);
            if (r < 15)      bus.rx_data = {3'd0, 8'($urandom_range(0, 20))};
            else if (r < 45) bus.rx_data = {3'd1, 8'($urandom)};
            else if (r < 60) bus.rx_data = {3'd2, 8'($urandom_range(0, 20))};
            else if (r < 72) bus.rx_data = {3'd3, 8'($urandom)};
            else if (r < 87) bus.rx_data = {3'd4, 8'($urandom_range(0, 6))};
            else if (r < 89) bus.rx_data = {3'd5, 8'($urandom)};
            else if (r < 94) bus.rx_data = {3'($urandom_range(6, 7)), 8'($urandom)};
            else             bus.rx_data = {3'($urandom_range(0, 2) * 2), 8'($urandom_range(32, 255))};
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        idle_wait();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
